dst_frame_packer: RTL and testbench

//  Downstream of the matrix engine's wide result stream. Splits each IN_W-bit beat into

---
 rtl/dst_frame_pkg.sv | 29 ++
 rtl/dst_frame_packer_beat_counter.sv | 54 +++++
 rtl/dst_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_dst_frame_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_frame_pkg.sv
// Shared types and sizing helpers for the destination frame packer.
// The build option DST_FRAME_STATS_EN adds frame and stall counters to the top level.
package dst_frame_pkg;

  // Default stream geometry
  localparam int DEF_IN_W  = 1024;
  localparam int DEF_OUT_W = 64;
  localparam int DEF_LEN_W = 16;

  // Number of narrow beats carved from one wide beat
  function automatic int ratio_f(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Width of the slice selector
  function automatic int sel_w_f(input int in_w, input int out_w);
    return $clog2(in_w / out_w);
  endfunction

  localparam int RATIO = ratio_f(DEF_IN_W, DEF_OUT_W);
  localparam int SEL_W = sel_w_f(DEF_IN_W, DEF_OUT_W);

  // The FSM state is exactly "is a wide word held"
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/dst_frame_packer_beat_counter.sv
// Output beat counter: tracks position inside the current frame and raises TLAST.
// The frame length is captured on the first beat of every frame, so frame_len edits
// made mid-frame only take effect from the next frame.
module frame_beat_counter #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             beat_fire,
  input  logic             tvalid,
  input  logic [LEN_W-1:0] frame_len,
  output logic             tlast,
  output logic [LEN_W-1:0] beat_cnt
);

  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_eff;
  logic             at_last;

  // Frame position bookkeeping; at the start of a frame the live frame_len governs
  always_comb begin
    len_eff    = (beat_cnt_q == '0) ? frame_len : len_q;
    at_last    = (len_eff != '0) && (beat_cnt_q == (len_eff - LEN_W'(1)));
    tlast      = tvalid & at_last;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    if (clr) begin
      beat_cnt_d = '0;
      len_d      = '0;
    end else if (beat_fire) begin
      if (beat_cnt_q == '0) begin
        len_d = frame_len;
      end
      // Stream mode (length 0) simply wraps modulo 2^LEN_W
      beat_cnt_d = at_last ? '0 : (beat_cnt_q + LEN_W'(1));
    end
  end

  // Counter and captured-length registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
    end
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: rtl/dst_frame_packer.sv
// Wide-to-narrow AXI-Stream packer: holds one IN_W word and emits it as IN_W/OUT_W
// narrow beats, LSB slice first, inserting TLAST every frame_len beats.
// Optional build macro DST_FRAME_STATS_EN adds frame_cnt and stall_cnt outputs.
module dst_frame_packer
  import dst_frame_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic               AXIS_ACLK,
  input  logic               AXIS_ARESETN,
  input  logic               clr,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               S_AXIS_TVALID,
  output logic               S_AXIS_TREADY,
  input  logic [IN_W-1:0]    S_AXIS_TDATA,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic [OUT_W-1:0]   M_AXIS_TDATA,
  output logic [OUT_W/8-1:0] M_AXIS_TSTRB,
  output logic               M_AXIS_TLAST,
  output logic               busy
`ifdef DST_FRAME_STATS_EN
  ,
  output logic [31:0]        frame_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int NUM_SLICES = ratio_f(IN_W, OUT_W);
  localparam int SEL_BITS   = sel_w_f(IN_W, OUT_W);

  state_e              state_q, state_d;
  logic [IN_W-1:0]     hold_q, hold_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic                last_sel;
  logic                s_ready;
  logic                s_fire;
  logic                m_fire;
  logic                tlast;
  logic [LEN_W-1:0]    beat_cnt;
  logic [OUT_W-1:0]    slice_w [NUM_SLICES];

  // Break the held word into its narrow slices
  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    assign slice_w[gi] = hold_q[gi*OUT_W +: OUT_W];
  end

  assign last_sel = (sel_q == SEL_BITS'(NUM_SLICES - 1));

  // Next-state, slice select and handshakes; clr overrides everything
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    s_ready = 1'b0;
    m_fire  = 1'b0;
    if (!clr) begin
      // Accept a new word when empty, or when the last slice leaves this cycle
      s_ready = (state_q == ST_EMPTY) | (last_sel & M_AXIS_TREADY);
      m_fire  = (state_q == ST_FULL) & M_AXIS_TREADY;
    end
    s_fire = S_AXIS_TVALID & s_ready;
    if (clr) begin
      state_d = ST_EMPTY;
      sel_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (s_fire) begin
            hold_d  = S_AXIS_TDATA;
            sel_d   = '0;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (m_fire) begin
            if (last_sel) begin
              sel_d = '0;
              if (s_fire) begin
                hold_d = S_AXIS_TDATA;
              end else begin
                state_d = ST_EMPTY;
              end
            end else begin
              sel_d = sel_q + SEL_BITS'(1);
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, held word and slice pointer
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  frame_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .clr       (clr),
    .beat_fire (m_fire),
    .tvalid    (M_AXIS_TVALID),
    .frame_len (frame_len),
    .tlast     (tlast),
    .beat_cnt  (beat_cnt)
  );

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = (state_q == ST_FULL);
  assign M_AXIS_TDATA  = slice_w[sel_q];
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = tlast;
  assign busy          = (state_q == ST_FULL) | (beat_cnt != '0);

`ifdef DST_FRAME_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Completed frames (wrapping) and back-pressure cycles (saturating)
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clr) begin
      frame_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (m_fire & tlast) begin
        frame_cnt_d = frame_cnt_q + 32'd1;
      end
      if (M_AXIS_TVALID & ~M_AXIS_TREADY & (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dst_frame_packer.sv
// Self-checking bench for dst_frame_packer: table of stream scenarios plus a
// hand-written clr / asynchronous-reset sequence, checked against a queue-based model.
module tb_dst_frame_packer;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 64;
  localparam int LEN_W = 16;
  localparam int RATIO = IN_W / OUT_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic [LEN_W-1:0]   frame_len = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [IN_W-1:0]    s_data = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [OUT_W-1:0]   m_data;
  logic [OUT_W/8-1:0] m_strb;
  logic               m_last;
  logic               busy;
`ifdef DST_FRAME_STATS_EN
  logic [31:0]        frame_cnt;
  logic [31:0]        stall_cnt;
`endif

  always #5 clk = ~clk;

  dst_frame_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .clr           (clr),
    .frame_len     (frame_len),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TREADY (s_ready),
    .S_AXIS_TDATA  (s_data),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TREADY (m_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TSTRB  (m_strb),
    .M_AXIS_TLAST  (m_last),
    .busy          (busy)
`ifdef DST_FRAME_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: expected narrow beats in order, frame position, stats
  logic [OUT_W-1:0] exp_q[$];
  int pos = 0, cur_len = 0, stall_m = 0, frames_m = 0, cyc = 0;
  bit prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;

  // Per-scenario observations
  int beat_idx = 0;
  int last_idx[$];
  bit sready_at[$];
  int first_beat_cyc = -1, last_beat_cyc = -1, first_acc_cyc = -1;

  typedef struct {
    int len; int nwords; int ready_pct; int chg_at; int chg_len; bit pattern;
    int exp_lasts; int exp_l1; int exp_l2; int exp_span;
  } row_t;
  row_t rows[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void flush_model();
    exp_q.delete();
    pos = 0;
    prev_stall = 1'b0;
    stall_m = 0;
    frames_m = 0;
  endfunction

  // One clock: caller has driven inputs at the falling edge; sample 1 ns later.
  task automatic step(output bit s_fire, output bit m_fire);
    bit mv, mr, sv, sr, ml, exp_last;
    logic [OUT_W-1:0] md;
    #1;
    mv = m_valid; mr = m_ready; sv = s_valid; sr = s_ready; ml = m_last; md = m_data;
    s_fire = 1'b0;
    m_fire = 1'b0;
    if (!rst_n || clr) begin
      flush_model();
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 64'(mv), 64'd1);
        chk("stall_data_held", md, prev_data);
      end
      if (mv) chk("valid_has_data", 64'(exp_q.size() != 0), 64'd1);
      if (mv && mr && exp_q.size() != 0) begin
        m_fire = 1'b1;
        if (pos == 0) cur_len = int'(frame_len);
        exp_last = (cur_len != 0) && (pos == cur_len - 1);
        chk("beat_data", md, exp_q.pop_front());
        chk("beat_last", 64'(ml), 64'(exp_last));
        pos = exp_last ? 0 : (pos + 1) % (1 << LEN_W);
        if (exp_last) frames_m++;
        if (ml) last_idx.push_back(beat_idx);
        sready_at.push_back(sr);
        if (beat_idx == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beat_idx++;
      end
      if (mv && !mr) stall_m++;
      prev_stall = mv && !mr;
      prev_data = md;
      if (sv && sr) begin
        s_fire = 1'b1;
        for (int k = 0; k < RATIO; k++) exp_q.push_back(s_data[k*OUT_W +: OUT_W]);
      end
    end
    $display("cyc %0d: s_fire=%0b m_fire=%0b data=%h last=%0b", cyc, s_fire, m_fire, md, ml);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_last"}, 64'(m_last), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_strb"}, 64'(m_strb), 64'hFF);
  endtask

  function automatic logic [IN_W-1:0] make_word(input bit pattern, input int w);
    logic [IN_W-1:0] d;
    for (int k = 0; k < RATIO; k++)
      d[k*OUT_W +: OUT_W] = 64'h0101010101010101 * 64'(k + w * RATIO);
    if (!pattern)
      for (int j = 0; j < IN_W / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic start_scenario(input int len);
    bit sf, mf;
    frame_len = LEN_W'(len);
    clr = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    step(sf, mf);
    clr = 1'b0;
    beat_idx = 0; last_idx.delete(); sready_at.delete();
    first_beat_cyc = -1; last_beat_cyc = -1; first_acc_cyc = -1;
  endtask

  task automatic run_row(input row_t r);
    logic [IN_W-1:0] words[$];
    int sent = 0, budget = 0;
    bit sf, mf;
    for (int w = 0; w < r.nwords; w++) words.push_back(make_word(r.pattern, w));
    start_scenario(r.len);
    while ((sent < r.nwords || exp_q.size() != 0) && budget < 4000) begin
      if (r.chg_at >= 0 && beat_idx == r.chg_at) frame_len = LEN_W'(r.chg_len);
      s_valid = (sent < r.nwords);
      if (sent < r.nwords) s_data = words[sent];
      m_ready = ($urandom_range(99) < r.ready_pct);
      step(sf, mf);
      if (sf) begin
        if (sent == 0) first_acc_cyc = cyc - 1;
        sent++;
      end
      budget++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("row_timeout", 64'(budget < 4000), 64'd1);
  endtask

  // Accept one word with TREADY high and stop once stop_beats beats have left
  task automatic feed(input logic [IN_W-1:0] w, input int stop_beats);
    bit sf, mf, acc;
    int budget = 0;
    acc = 1'b0;
    beat_idx = 0; last_idx.delete(); sready_at.delete();
    while (beat_idx < stop_beats && budget < 200) begin
      s_valid = !acc; s_data = w; m_ready = 1'b1;
      step(sf, mf);
      if (sf) acc = 1'b1;
      budget++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("feed_timeout", 64'(budget < 200), 64'd1);
  endtask

  initial begin
    bit sf, mf;
    logic [IN_W-1:0] w;
    //        len nw rdy chg clen pat lasts l1  l2  span
    rows[0] = '{16, 1, 100, -1, 0, 1'b1,  1, 15, -1, 16};
    rows[1] = '{16, 3, 100, -1, 0, 1'b0,  3, 15, 31, 48};
    rows[2] = '{24, 3, 100, -1, 0, 1'b0,  2, 23, 47, 48};
    rows[3] = '{24, 3, 100, 10, 8, 1'b0,  4, 23, 31, 48};
    rows[4] = '{16, 6,  50, -1, 0, 1'b0,  6, 15, 31, -1};
    rows[5] = '{ 0, 4, 100, -1, 0, 1'b0,  0, -1, -1, 64};
    rows[6] = '{ 5, 2,  50, -1, 0, 1'b0,  6,  4,  9, -1};
    rows[7] = '{ 1, 1, 100, -1, 0, 1'b0, 16,  0,  1, 16};

    // Reset values
    repeat (2) @(negedge clk);
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (rows[i]) begin
      run_row(rows[i]);
      chk($sformatf("row%0d_beats", i), 64'(beat_idx), 64'(rows[i].nwords * RATIO));
      chk($sformatf("row%0d_lasts", i), 64'(last_idx.size()), 64'(rows[i].exp_lasts));
      if (rows[i].exp_l1 >= 0 && last_idx.size() > 0)
        chk($sformatf("row%0d_last1", i), 64'(last_idx[0]), 64'(rows[i].exp_l1));
      if (rows[i].exp_l2 >= 0 && last_idx.size() > 1)
        chk($sformatf("row%0d_last2", i), 64'(last_idx[1]), 64'(rows[i].exp_l2));
      if (rows[i].exp_span >= 0) begin
        chk($sformatf("row%0d_span", i), 64'(last_beat_cyc - first_beat_cyc + 1),
            64'(rows[i].exp_span));
        chk($sformatf("row%0d_latency", i), 64'(first_beat_cyc - first_acc_cyc), 64'd1);
      end
      if (rows[i].ready_pct == 100 && rows[i].nwords >= 3 && sready_at.size() > 31) begin
        chk($sformatf("row%0d_sready_b14", i), 64'(sready_at[14]), 64'd0);
        chk($sformatf("row%0d_sready_b15", i), 64'(sready_at[15]), 64'd1);
        chk($sformatf("row%0d_sready_b31", i), 64'(sready_at[31]), 64'd1);
      end
`ifdef DST_FRAME_STATS_EN
      chk($sformatf("row%0d_stall_cnt", i), 64'(stall_cnt), 64'(stall_m));
      chk($sformatf("row%0d_frame_cnt", i), 64'(frame_cnt), 64'(frames_m));
`endif
    end

    // clr at beat 5 of a word: handshake that cycle is ignored, packer empties
    start_scenario(16);
    feed(make_word(1'b0, 0), 5);
    clr = 1'b1; m_ready = 1'b1;
    step(sf, mf);
    clr = 1'b0; m_ready = 1'b0;
    check_idle("after_clr");

    // Asynchronous reset mid-word
    feed(make_word(1'b0, 1), 5);
    rst_n = 1'b0;
    check_idle("in_reset");
    step(sf, mf);
    rst_n = 1'b1;
    check_idle("after_reset");

    // Next frame begins at slice 0 with a fresh beat count
    w = make_word(1'b1, 0);
    feed(w, RATIO);
    chk("post_reset_beats", 64'(beat_idx), 64'(RATIO));
    chk("post_reset_last", 64'(last_idx.size() > 0 ? last_idx[0] : -1), 64'(RATIO - 1));
    repeat (2) step(sf, mf);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
